// File: rtl/legv8_exec_ctrl_pkg.sv
// Shared constants and types for the LEGv8 decode/execute slice.
// Covers opcodes, ALU operation codes, ALUOp encodings and the control-strobe bundle.
package legv8_exec_ctrl_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CBZ matches on instr[31:24]; instr[23:21] belong to the branch offset.
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_CBZ    = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_RTYPE2 = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg2loc;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        aluop_e aluop;
    } ctrl_t;

endpackage

// File: rtl/legv8_exec_ctrl_if.sv
// Datapath-facing signal bundle of the LEGv8 decode/execute slice.
// The master drives opcode and operands; the slave returns strobes and ALU results.
interface legv8_exec_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic [10:0]     opcode;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            reg2loc;
    logic            alusrc;
    logic            memtoreg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic [1:0]      aluop;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            pc_src;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    modport master (
        output opcode, alu_a, alu_b,
        input  reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop,
        input  alu_ctl, alu_result, zero, pc_src, result_q, zero_q
    );

    modport slave (
        input  opcode, alu_a, alu_b,
        output reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop,
        output alu_ctl, alu_result, zero, pc_src, result_q, zero_q
    );
endinterface

// File: rtl/legv8_alu_core.sv
// Combinational 64-bit LEGv8 ALU with zero detect.
// Undefined operation codes yield a zero result.
module legv8_alu_core
    import legv8_exec_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [3:0]      i_ctl,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    logic [XLEN-1:0] w_result;

    always_comb begin
        w_result = '0;
        case (i_ctl)
            ALU_AND:   w_result = i_a & i_b;
            ALU_ORR:   w_result = i_a | i_b;
            ALU_ADD:   w_result = i_a + i_b;
            ALU_SUB:   w_result = i_a - i_b;
            ALU_PASSB: w_result = i_b;
            ALU_NOR:   w_result = ~(i_a | i_b);
            default:   w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule

// File: rtl/legv8_exec_ctrl.sv
// LEGv8 single-cycle decode + execute slice: main controller, ALU-control decoder, ALU,
// and a status register holding the last result and zero flag.
module legv8_exec_ctrl
    import legv8_exec_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    legv8_exec_ctrl_if.slave bus
);

    ctrl_t           w_ctrl_dec;
    ctrl_t           w_ctrl;
    alu_op_e         w_alu_ctl;
    logic [XLEN-1:0] w_alu_result;
    logic            w_zero;
    logic [XLEN-1:0] r_result_q;
    logic            r_zero_q;

    always_comb begin
        w_ctrl_dec = '0;
        if (bus.opcode[10:3] == OP_CBZ) begin
            w_ctrl_dec.reg2loc = 1'b1;
            w_ctrl_dec.branch  = 1'b1;
            w_ctrl_dec.aluop   = ALUOP_CBZ;
        end else begin
            case (bus.opcode)
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    w_ctrl_dec.regwrite = 1'b1;
                    w_ctrl_dec.aluop    = ALUOP_RTYPE;
                end
                OP_LDUR: begin
                    w_ctrl_dec.alusrc   = 1'b1;
                    w_ctrl_dec.memtoreg = 1'b1;
                    w_ctrl_dec.regwrite = 1'b1;
                    w_ctrl_dec.memread  = 1'b1;
                    w_ctrl_dec.aluop    = ALUOP_MEM;
                end
                OP_STUR: begin
                    w_ctrl_dec.reg2loc  = 1'b1;
                    w_ctrl_dec.alusrc   = 1'b1;
                    w_ctrl_dec.memwrite = 1'b1;
                    w_ctrl_dec.aluop    = ALUOP_MEM;
                end
                default: w_ctrl_dec = '0;
            endcase
        end
    end

    // Strobes are gated during reset, but the ALU keeps decoding from the raw ALUOp.
    assign w_ctrl = reset_n ? w_ctrl_dec : '0;

    always_comb begin
        w_alu_ctl = ALU_ADD;
        case (w_ctrl_dec.aluop)
            ALUOP_MEM: w_alu_ctl = ALU_ADD;
            ALUOP_CBZ: w_alu_ctl = ALU_PASSB;
            default: begin
                case (bus.opcode)
                    OP_SUB:  w_alu_ctl = ALU_SUB;
                    OP_AND:  w_alu_ctl = ALU_AND;
                    OP_ORR:  w_alu_ctl = ALU_ORR;
                    default: w_alu_ctl = ALU_ADD;
                endcase
            end
        endcase
    end

    legv8_alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .i_ctl    (w_alu_ctl),
        .i_a      (bus.alu_a),
        .i_b      (bus.alu_b),
        .o_result (w_alu_result),
        .o_zero   (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
        end else begin
            r_result_q <= w_alu_result;
            r_zero_q   <= w_zero;
        end
    end

    assign bus.reg2loc    = w_ctrl.reg2loc;
    assign bus.alusrc     = w_ctrl.alusrc;
    assign bus.memtoreg   = w_ctrl.memtoreg;
    assign bus.regwrite   = w_ctrl.regwrite;
    assign bus.memread    = w_ctrl.memread;
    assign bus.memwrite   = w_ctrl.memwrite;
    assign bus.branch     = w_ctrl.branch;
    assign bus.aluop      = w_ctrl.aluop;
    assign bus.alu_ctl    = w_alu_ctl;
    assign bus.alu_result = w_alu_result;
    assign bus.zero       = w_zero;
    assign bus.pc_src     = w_ctrl.branch & w_zero;
    assign bus.result_q   = r_result_q;
    assign bus.zero_q     = r_zero_q;

endmodule

// File: tb/tb_legv8_exec_ctrl.sv
// Self-checking bench for legv8_exec_ctrl: a reference model fills scoreboard queues at drive
// time; combinational outputs are popped mid-cycle, registered outputs after the next edge.
module tb_legv8_exec_ctrl;

    localparam int unsigned XLEN = 64;

    typedef struct {
        logic [8:0]      ctrl;
        logic [3:0]      alu_ctl;
        logic [63:0]     res;
        logic            zero;
        logic            pc_src;
    } exp_comb_t;

    typedef struct {
        logic [63:0] res_q;
        logic        zero_q;
    } exp_reg_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    exp_comb_t q_comb[$];
    exp_reg_t  q_reg[$];

    legv8_exec_ctrl_if #(.XLEN(XLEN)) bus ();

    legv8_exec_ctrl #(
        .XLEN (XLEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Control bundle {reg2loc,alusrc,memtoreg,regwrite,memread,memwrite,branch,aluop[1:0]}.
    function automatic logic [8:0] model_ctrl(input logic [10:0] op);
        if (op[10:3] == 8'hB4)            return 9'b1_0_0_0_0_0_1_01;
        else if (op == 11'b10001011000 || op == 11'b11001011000 ||
                 op == 11'b10001010000 || op == 11'b10101010000)
                                          return 9'b0_0_0_1_0_0_0_10;
        else if (op == 11'b11111000010)   return 9'b0_1_1_1_1_0_0_00;
        else if (op == 11'b11111000000)   return 9'b1_1_0_0_0_1_0_00;
        else                              return 9'b0;
    endfunction

    function automatic logic [3:0] model_alu_ctl(input logic [10:0] op);
        logic [8:0] c;
        c = model_ctrl(op);
        if (c[1:0] == 2'b00) return 4'b0010;
        if (c[1:0] == 2'b01) return 4'b0111;
        if (op == 11'b11001011000) return 4'b0110;
        if (op == 11'b10001010000) return 4'b0000;
        if (op == 11'b10101010000) return 4'b0001;
        return 4'b0010;
    endfunction

    function automatic logic [63:0] model_alu(input logic [3:0] k, input logic [63:0] a,
                                              input logic [63:0] b);
        if (k == 4'b0000) return a & b;
        if (k == 4'b0001) return a | b;
        if (k == 4'b0010) return a + b;
        if (k == 4'b0110) return a - b;
        if (k == 4'b0111) return b;
        if (k == 4'b1100) return ~(a | b);
        return 64'd0;
    endfunction

    // Called #1 after a rising edge; returns #1 after the following rising edge.
    task automatic apply(input string tag, input logic rstn, input logic [10:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        exp_comb_t ec;
        exp_reg_t  er;
        exp_comb_t gc;
        exp_reg_t  gr;
        reset_n    = rstn;
        bus.opcode = op;
        bus.alu_a  = a;
        bus.alu_b  = b;
        ec.ctrl    = rstn ? model_ctrl(op) : 9'b0;
        ec.alu_ctl = model_alu_ctl(op);
        ec.res     = model_alu(ec.alu_ctl, a, b);
        ec.zero    = (ec.res == 64'd0);
        ec.pc_src  = ec.ctrl[2] & ec.zero;
        er.res_q   = rstn ? ec.res : 64'd0;
        er.zero_q  = rstn ? ec.zero : 1'b0;
        q_comb.push_back(ec);
        q_reg.push_back(er);
        #3;
        gc = q_comb.pop_front();
        check({tag, ".ctrl"}, 64'({bus.reg2loc, bus.alusrc, bus.memtoreg, bus.regwrite,
              bus.memread, bus.memwrite, bus.branch, bus.aluop}), 64'(gc.ctrl));
        check({tag, ".alu_ctl"}, 64'(bus.alu_ctl), 64'(gc.alu_ctl));
        check({tag, ".result"}, bus.alu_result, gc.res);
        check({tag, ".zero"}, 64'(bus.zero), 64'(gc.zero));
        check({tag, ".pc_src"}, 64'(bus.pc_src), 64'(gc.pc_src));
        @(posedge clk);
        #1;
        gr = q_reg.pop_front();
        check({tag, ".result_q"}, bus.result_q, gr.res_q);
        check({tag, ".zero_q"}, 64'(bus.zero_q), 64'(gr.zero_q));
    endtask

    initial begin
        logic [10:0] ops [8];
        logic [63:0] ra;
        logic [63:0] rb;
        logic [10:0] rop;
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        bus.opcode = '0;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        ops[0] = 11'b10001011000;
        ops[1] = 11'b11001011000;
        ops[2] = 11'b10001010000;
        ops[3] = 11'b10101010000;
        ops[4] = 11'b11111000010;
        ops[5] = 11'b11111000000;
        ops[6] = 11'b10110100011;
        ops[7] = 11'b01010101010;
        @(posedge clk);
        #1;

        apply("reset_idle", 1'b0, 11'b0, 64'd3, 64'd4);
        apply("add", 1'b1, 11'b10001011000, 64'd5, 64'd7);
        check("add.direct_q", bus.result_q, 64'd12);
        apply("sub_eq", 1'b1, 11'b11001011000, 64'd9, 64'd9);
        apply("ldur", 1'b1, 11'b11111000010, 64'h100, 64'h8);
        check("ldur.direct_q", bus.result_q, 64'h108);
        apply("stur", 1'b1, 11'b11111000000, 64'h100, 64'h8);
        apply("cbz_taken", 1'b1, 11'b10110100101, 64'd77, 64'd0);
        apply("cbz_not", 1'b1, 11'b10110100101, 64'd77, 64'd3);
        apply("and", 1'b1, 11'b10001010000, 64'hF0F0, 64'h0FF0);
        check("and.direct_q", bus.result_q, 64'h00F0);
        apply("orr", 1'b1, 11'b10101010000, 64'hF0F0, 64'h0FF0);
        check("orr.direct_q", bus.result_q, 64'hFFF0);
        apply("add_wrap", 1'b1, 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        apply("stur_rst", 1'b0, 11'b11111000000, 64'h40, 64'h8);
        apply("unknown", 1'b1, 11'b0, 64'd6, 64'd1);
        apply("cbz_rst", 1'b0, 11'b10110100000, 64'd1, 64'd0);

        for (int i = 0; i < 12; i++) begin
            rop = ops[$urandom_range(0, 7)];
            ra  = {$urandom, $urandom};
            rb  = (i % 3 == 0) ? 64'd0 : {$urandom, $urandom};
            apply($sformatf("rand%0d", i), 1'b1, rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
